// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: 2W-bit dividend by W-bit divisor, one quotient bit
// per clock, with valid/ready handshakes on both sides.
module seq_restoring_divider #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W:0]      rem_q, rem_d;
    logic [W-1:0]    low_q, low_d;
    logic [W-1:0]    divisor_q, divisor_d;
    logic [W-1:0]    quo_q, quo_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    logic [W:0]      trial;
    logic [W:0]      diff;
    logic            fits;

    // Bring down the next dividend bit; R stays below the divisor, so R[W] is always zero here.
    assign trial = {rem_q[W-1:0], low_q[count_q]};
    assign fits  = trial >= {1'b0, divisor_q};
    assign diff  = trial - {1'b0, divisor_q};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        low_d     = low_q;
        divisor_d = divisor_q;
        quo_d     = quo_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    divisor_d = divisor;
                    low_d     = dividend[W-1:0];
                    if (divisor == '0) begin
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        quo_d   = '1;
                        rem_d   = '0;
                        state_d = StDone;
                    end else if (dividend[2*W-1:W] >= divisor) begin
                        // Quotient would need more than W bits.
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = '0;
                        state_d = StDone;
                    end else begin
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b0;
                        quo_d   = '0;
                        rem_d   = {1'b0, dividend[2*W-1:W]};
                        count_d = CW'(W - 1);
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                rem_d          = fits ? diff : trial;
                quo_d[count_q] = fits;
                if (count_q == '0) begin
                    state_d = StDone;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            rem_q     <= '0;
            low_q     <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            low_q     <= low_d;
            divisor_q <= divisor_d;
            quo_q     <= quo_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign quotient    = quo_q;
    assign remainder   = rem_q[W-1:0];
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
